// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the F/D/E/M/W pipeline, including the multi-cycle divider FSM.
// Optional macro STALL_STATS_EN adds a saturating stall_cycles counter output.
module pipe_stall_ctrl #(
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic lw_hazard_d,
    input  logic div_req_e,
    input  logic mem_wait_m,
    input  logic branch_taken_d,
    output logic en_f,
    output logic en_d,
    output logic en_e,
    output logic en_m,
    output logic en_w,
    output logic flush_d,
    output logic flush_e,
    output logic flush_m,
    output logic div_start,
    output logic div_busy,
    output logic div_done
`ifdef STALL_STATS_EN
    ,
    output logic [31:0] stall_cycles
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             div_stall;

    // The counter reaches 0 on the edge into DIV_DONE, so div_done rises DIV_LAT cycles after div_start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (div_req_e && !mem_wait_m) begin
                        state <= DIV_RUN;
                        cnt   <= CNT_W'(DIV_LAT - 1);
                    end
                end
                DIV_RUN: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    if (!mem_wait_m) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign div_stall = ((state == IDLE) && div_req_e) || (state == DIV_RUN);

    always_comb begin
        en_f      = 1'b1;
        en_d      = 1'b1;
        en_e      = 1'b1;
        en_m      = 1'b1;
        en_w      = 1'b1;
        flush_d   = 1'b0;
        flush_e   = 1'b0;
        flush_m   = 1'b0;
        div_start = 1'b0;
        div_busy  = 1'b0;
        div_done  = 1'b0;
        if (!rst) begin
            div_busy  = (state != IDLE);
            div_done  = (state == DIV_DONE);
            div_start = (state == IDLE) && div_req_e && !mem_wait_m;
            if (mem_wait_m) begin
                en_f = 1'b0;
                en_d = 1'b0;
                en_e = 1'b0;
                en_m = 1'b0;
                en_w = 1'b0;
            end else if (div_stall) begin
                en_f    = 1'b0;
                en_d    = 1'b0;
                en_e    = 1'b0;
                flush_m = 1'b1;
            end else if (lw_hazard_d) begin
                en_f    = 1'b0;
                en_d    = 1'b0;
                flush_e = 1'b1;
            end
            // A stalled IF/ID must keep its instruction, so the branch flush waits.
            flush_d = branch_taken_d && en_d;
        end
    end

`ifdef STALL_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (!en_f && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: directed per-cycle vectors with hand-computed output words.
`timescale 1ns/1ps
module tb_pipe_stall_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic lw_hazard_d = 1'b0;
    logic div_req_e = 1'b0;
    logic mem_wait_m = 1'b0;
    logic branch_taken_d = 1'b0;
    logic en_f, en_d, en_e, en_m, en_w;
    logic flush_d, flush_e, flush_m;
    logic div_start, div_busy, div_done;
`ifdef STALL_STATS_EN
    logic [31:0] stall_cycles;
`endif

    always #5 clk = ~clk;

    pipe_stall_ctrl #(.DIV_LAT(32), .CNT_W(6)) dut (
        .clk(clk),
        .rst(rst),
        .lw_hazard_d(lw_hazard_d),
        .div_req_e(div_req_e),
        .mem_wait_m(mem_wait_m),
        .branch_taken_d(branch_taken_d),
        .en_f(en_f),
        .en_d(en_d),
        .en_e(en_e),
        .en_m(en_m),
        .en_w(en_w),
        .flush_d(flush_d),
        .flush_e(flush_e),
        .flush_m(flush_m),
        .div_start(div_start),
        .div_busy(div_busy),
        .div_done(div_done)
`ifdef STALL_STATS_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    // Output word: {en_f,en_d,en_e,en_m,en_w, flush_d,flush_e,flush_m, div_start,div_busy,div_done}
    localparam logic [10:0] NORM       = 11'b11111_000_000;
    localparam logic [10:0] BR         = 11'b11111_100_000;
    localparam logic [10:0] LW         = 11'b00111_010_000;
    localparam logic [10:0] DSTART     = 11'b00011_001_100;
    localparam logic [10:0] DRUN       = 11'b00011_001_010;
    localparam logic [10:0] DDONE      = 11'b11111_000_011;
    localparam logic [10:0] DDONE_LW   = 11'b00111_010_011;
    localparam logic [10:0] MW_IDLE    = 11'b00000_000_000;
    localparam logic [10:0] MW_RUN     = 11'b00000_000_010;
    localparam logic [10:0] MW_DONE    = 11'b00000_000_011;

    logic [10:0] exp_q[$];
    string       name_q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    logic [10:0] act;
    logic [10:0] exp_v;
    string       nm;

    task automatic step(input logic r, input logic lw, input logic dv, input logic mw,
                        input logic br, input logic [10:0] exp, input string name);
        @(posedge clk);
        #1;
        rst            = r;
        lw_hazard_d    = lw;
        div_req_e      = dv;
        mem_wait_m     = mw;
        branch_taken_d = br;
        exp_q.push_back(exp);
        name_q.push_back(name);
    endtask

    // Monitor: every cycle presents an output word; compare it against the oldest expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            nm    = name_q.pop_front();
            act   = {en_f, en_d, en_e, en_m, en_w, flush_d, flush_e, flush_m,
                     div_start, div_busy, div_done};
            n_tests++;
            if (act !== exp_v) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b", nm, act, exp_v);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, with inputs that would otherwise stall or flush.
        step(1, 0, 0, 0, 0, NORM, "reset_idle");
        step(1, 1, 1, 1, 1, NORM, "reset_gated");
        step(0, 0, 0, 0, 0, NORM, "post_reset");

        // Load-use, then load-use with branch, then branch alone.
        step(0, 1, 0, 0, 0, LW,   "lw_stall");
        step(0, 0, 0, 0, 0, NORM, "lw_release");
        step(0, 1, 0, 0, 1, LW,   "lw_beats_branch");
        step(0, 0, 0, 0, 1, BR,   "branch_flush");
        step(0, 0, 0, 0, 0, NORM, "branch_release");

        // mem_wait blocks a divide start in IDLE.
        step(0, 0, 1, 1, 0, MW_IDLE, "memwait_blocks_start");

        // Divide #1 with nothing else going on: 1 IDLE-stall + 31 DIV_RUN + DIV_DONE.
        step(0, 0, 1, 0, 0, DSTART, "div1_start");
        for (int i = 0; i < 31; i++) begin
            if (i == 10) step(0, 0, 1, 0, 1, DRUN, "div1_run_branch");
            else         step(0, 0, 1, 0, 0, DRUN, "div1_run");
        end
        step(0, 0, 1, 0, 0, DDONE, "div1_done_no_restart");

        // Back-to-back: request still high right after the return to IDLE.
        step(0, 0, 1, 0, 0, DSTART, "div2_start");
        for (int i = 0; i < 26; i++) step(0, 0, 1, 0, 0, DRUN, "div2_run");
        // mem_wait for 8 cycles starting at counter=5: 5 more RUN cycles, then 3 in DONE.
        for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 1, MW_RUN, "div2_memwait_run");
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0, MW_DONE, "div2_memwait_done");
        step(0, 1, 1, 0, 0, DDONE_LW, "div2_done_lw");
        step(0, 0, 0, 0, 0, NORM, "div2_idle");

        // Divide #3 interrupted by reset at counter=10.
        step(0, 0, 1, 0, 0, DSTART, "div3_start");
        for (int i = 0; i < 21; i++) step(0, 0, 1, 0, 0, DRUN, "div3_run");
        step(1, 0, 1, 0, 0, NORM, "reset_mid_div");
        step(1, 0, 1, 0, 0, NORM, "reset_hold");
        step(0, 0, 0, 0, 0, NORM, "after_reset_idle");
        step(0, 0, 1, 0, 0, DSTART, "div4_start_from_idle");
        for (int i = 0; i < 31; i++) step(0, 0, 1, 0, 0, DRUN, "div4_run");
        step(0, 0, 0, 0, 1, 11'b11111_100_011, "div4_done_branch");
        step(0, 0, 0, 0, 0, NORM, "div4_idle");

        @(posedge clk);
        @(posedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
